// File: rtl/alu_arbiter_if.sv
// Request, response, ALU and flag signals between the arbiter and its neighbours.
// The arbiter uses the slave modport; requesters, the consumer and the ALU use the master side.
interface alu_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_upd_flags;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_upd_flags;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              resp_c;
  logic              resp_z;

  logic [2:0]        alu_operation;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_c;
  logic              alu_c_flag;
  logic              alu_z_flag;

  logic              flags_c;
  logic              flags_z;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_upd_flags,
    input  req1_valid, req1_op, req1_a, req1_b, req1_upd_flags,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_c, resp_z,
    input  resp_ready,
    output alu_operation, alu_a, alu_b,
    input  alu_c, alu_c_flag, alu_z_flag,
    output flags_c, flags_z
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_upd_flags,
    output req1_valid, req1_op, req1_a, req1_b, req1_upd_flags,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_c, resp_z,
    output resp_ready,
    input  alu_operation, alu_a, alu_b,
    output alu_c, alu_c_flag, alu_z_flag,
    input  flags_c, flags_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter for one shared ALU: accept -> response valid 2 cycles later, 3 cycles per op minimum.
// Backpressure: a stalled response holds the FSM in RESP; no requester gets ready until the handshake.
module alu_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int DATA_W         = 8
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              id_q;
  logic              upd_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  logic              resp_valid_q;
  logic              resp_id_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_c_q;
  logic              resp_z_q;
  logic              flags_c_q;
  logic              flags_z_q;

  logic              idle;
  logic              rr_pick1;
  logic              win1;
  logic              any_req;

  // On a tie, round-robin hands port 1 the grant only if port 0 had the last one.
  assign idle     = (state == IDLE);
  assign rr_pick1 = (FIXED_PRIORITY == 0) && !last_grant;
  assign win1     = bus.req1_valid && (!bus.req0_valid || rr_pick1);
  assign any_req  = bus.req0_valid || bus.req1_valid;

  assign bus.req0_ready = idle && bus.req0_valid && !win1;
  assign bus.req1_ready = idle && win1;

  // The ALU sees only latched operands, so its inputs never move outside an accept.
  assign bus.alu_operation = op_q;
  assign bus.alu_a         = a_q;
  assign bus.alu_b         = b_q;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_c     = resp_c_q;
  assign bus.resp_z     = resp_z_q;
  assign bus.flags_c    = flags_c_q;
  assign bus.flags_z    = flags_z_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      id_q         <= 1'b0;
      upd_q        <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_c_q     <= 1'b0;
      resp_z_q     <= 1'b0;
      flags_c_q    <= 1'b0;
      flags_z_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_q       <= win1 ? bus.req1_op        : bus.req0_op;
            a_q        <= win1 ? bus.req1_a         : bus.req0_a;
            b_q        <= win1 ? bus.req1_b         : bus.req0_b;
            upd_q      <= win1 ? bus.req1_upd_flags : bus.req0_upd_flags;
            id_q       <= win1;
            last_grant <= win1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_valid_q <= 1'b1;
          resp_id_q    <= id_q;
          resp_data_q  <= bus.alu_c;
          resp_c_q     <= bus.alu_c_flag;
          resp_z_q     <= bus.alu_z_flag;
          // Flags commit here, independent of when the consumer takes the response.
          if (upd_q) begin
            flags_c_q <= bus.alu_c_flag;
            flags_z_q <= bus.alu_z_flag;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard;
// a fixed-priority instance shares the request stimulus for the starvation check.
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       c;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   log_en = 1'b0;

  exp_t sb[$];
  int   g_port[$];
  int   g_cyc[$];
  int   f_port[$];
  int   f_cyc[$];

  alu_arbiter_if #(.DATA_W(8)) bus ();
  alu_arbiter_if #(.DATA_W(8)) bus_fp ();

  alu_arbiter #(.FIXED_PRIORITY(0), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_arbiter #(.FIXED_PRIORITY(1), .DATA_W(8)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {z, c, data}; c is carry-out for add/inc and NOT-borrow for sub/dec.
  function automatic logic [9:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      OP_ADD:  s = {1'b0, a} + {1'b0, b};
      OP_SUB:  begin s = {1'b0, a} - {1'b0, b}; s[8] = ~s[8]; end
      OP_INC:  s = {1'b0, a} + 9'd1;
      OP_DEC:  begin s = {1'b0, a} - 9'd1; s[8] = ~s[8]; end
      default: s = {1'b0, a ^ b};
    endcase
    return {(s[7:0] == 8'h00), s[8], s[7:0]};
  endfunction

  assign {bus.alu_z_flag, bus.alu_c_flag, bus.alu_c} =
         alu_calc(bus.alu_operation, bus.alu_a, bus.alu_b);
  assign {bus_fp.alu_z_flag, bus_fp.alu_c_flag, bus_fp.alu_c} =
         alu_calc(bus_fp.alu_operation, bus_fp.alu_a, bus_fp.alu_b);

  assign bus_fp.req0_valid     = bus.req0_valid;
  assign bus_fp.req0_op        = bus.req0_op;
  assign bus_fp.req0_a         = bus.req0_a;
  assign bus_fp.req0_b         = bus.req0_b;
  assign bus_fp.req0_upd_flags = bus.req0_upd_flags;
  assign bus_fp.req1_valid     = bus.req1_valid;
  assign bus_fp.req1_op        = bus.req1_op;
  assign bus_fp.req1_a         = bus.req1_a;
  assign bus_fp.req1_b         = bus.req1_b;
  assign bus_fp.req1_upd_flags = bus.req1_upd_flags;
  assign bus_fp.resp_ready     = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic upd);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_upd_flags = upd;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic upd);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_upd_flags = upd;
  endtask

  // Scoreboard: compare every visible response against the oldest expectation, push on each grant.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid) begin
        chk("resp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("sb_id",   bus.resp_id,   sb[0].id);
          chk("sb_data", bus.resp_data, sb[0].data);
          chk("sb_c",    bus.resp_c,    sb[0].c);
          chk("sb_z",    bus.resp_z,    sb[0].z);
          if (bus.resp_ready) void'(sb.pop_front());
        end
      end
      if (bus.req0_ready) begin
        exp_t e;
        e.id = 1'b0;
        {e.z, e.c, e.data} = alu_calc(bus.req0_op, bus.req0_a, bus.req0_b);
        sb.push_back(e);
      end
      if (bus.req1_ready) begin
        exp_t e;
        e.id = 1'b1;
        {e.z, e.c, e.data} = alu_calc(bus.req1_op, bus.req1_a, bus.req1_b);
        sb.push_back(e);
      end
      if (log_en) begin
        if (bus.req0_ready)    begin g_port.push_back(0); g_cyc.push_back(cyc); end
        if (bus.req1_ready)    begin g_port.push_back(1); g_cyc.push_back(cyc); end
        if (bus_fp.req0_ready) begin f_port.push_back(0); f_cyc.push_back(cyc); end
        if (bus_fp.req1_ready) begin f_port.push_back(1); f_cyc.push_back(cyc); end
      end
    end
  end

  initial begin
    drive0(0, OP_ADD, 0, 0, 0);
    drive1(0, OP_ADD, 0, 0, 0);
    bus.resp_ready = 1'b1;

    // Reset state
    smp(); smp();
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data",  bus.resp_data, 0);
    chk("rst_flags",      {bus.flags_c, bus.flags_z}, 0);
    chk("rst_alu_in",     {bus.alu_operation, bus.alu_a, bus.alu_b}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Port 0 add F0+20 with flag update
    drive0(1, OP_ADD, 8'hF0, 8'h20, 1);
    smp(); chk("t1_req0_ready", bus.req0_ready, 1); chk("t1_req1_ready", bus.req1_ready, 0);
    step(); drive0(0, OP_ADD, 0, 0, 0);
    smp(); chk("t1_exec_valid", bus.resp_valid, 0);
    chk("t1_alu_op", bus.alu_operation, OP_ADD);
    chk("t1_alu_a", bus.alu_a, 8'hF0); chk("t1_alu_b", bus.alu_b, 8'h20);
    step(); smp();
    chk("t1_valid", bus.resp_valid, 1); chk("t1_id", bus.resp_id, 0);
    chk("t1_data", bus.resp_data, 8'h10); chk("t1_c", bus.resp_c, 1); chk("t1_z", bus.resp_z, 0);
    chk("t1_flags_c", bus.flags_c, 1); chk("t1_flags_z", bus.flags_z, 0);
    step(); smp();
    chk("t1_valid_clr", bus.resp_valid, 0); chk("t1_alu_a_held", bus.alu_a, 8'hF0);

    // Port 1 sub 5-5 without flag update
    step(); drive1(1, OP_SUB, 8'h05, 8'h05, 0);
    smp(); chk("t2_req1_ready", bus.req1_ready, 1);
    step(); drive1(0, OP_ADD, 0, 0, 0);
    step(); smp();
    chk("t2_id", bus.resp_id, 1); chk("t2_data", bus.resp_data, 8'h00);
    chk("t2_c", bus.resp_c, 1); chk("t2_z", bus.resp_z, 1);
    chk("t2_flags", {bus.flags_c, bus.flags_z}, 2'b10);

    // Both ports valid continuously: round-robin vs fixed priority
    step();
    g_port.delete(); g_cyc.delete(); f_port.delete(); f_cyc.delete();
    log_en = 1'b1;
    drive0(1, OP_ADD, 8'h01, 8'h02, 0);
    drive1(1, OP_SUB, 8'h09, 8'h04, 0);
    repeat (10) step();
    drive0(0, OP_ADD, 0, 0, 0);
    drive1(0, OP_ADD, 0, 0, 0);
    log_en = 1'b0;
    repeat (4) step();
    chk("rr_grants", g_port.size(), 4);
    chk("fp_grants", f_port.size(), 4);
    for (int i = 0; i < 4 && i < g_port.size(); i++) begin
      chk($sformatf("rr_port%0d", i), g_port[i], i % 2);
      if (i > 0) chk($sformatf("rr_gap%0d", i), g_cyc[i] - g_cyc[i-1], 3);
    end
    for (int i = 0; i < 4 && i < f_port.size(); i++) begin
      chk($sformatf("fp_port%0d", i), f_port[i], 0);
      if (i > 0) chk($sformatf("fp_gap%0d", i), f_cyc[i] - f_cyc[i-1], 3);
    end

    // Decrement 0 with stalled response; port 1 waits meanwhile
    drive0(1, OP_DEC, 8'h00, 8'h00, 1);
    bus.resp_ready = 1'b0;
    smp(); chk("t4_req0_ready", bus.req0_ready, 1);
    step(); drive0(0, OP_ADD, 0, 0, 0); drive1(1, OP_INC, 8'h10, 8'h00, 0);
    smp(); chk("t4_exec_req1", bus.req1_ready, 0); chk("t4_flags_pre", bus.flags_c, 1);
    for (int i = 0; i < 5; i++) begin
      step(); smp();
      chk("t4_valid", bus.resp_valid, 1); chk("t4_data", bus.resp_data, 8'hFF);
      chk("t4_c", bus.resp_c, 0); chk("t4_z", bus.resp_z, 0);
      chk("t4_flags", {bus.flags_c, bus.flags_z}, 2'b00);
      chk("t4_req1_wait", bus.req1_ready, 0);
    end
    step(); bus.resp_ready = 1'b1;
    smp(); chk("t4_hs_req1", bus.req1_ready, 0);
    step(); smp(); chk("t4_req1_ready", bus.req1_ready, 1); chk("t4_valid_clr", bus.resp_valid, 0);
    step(); drive1(0, OP_ADD, 0, 0, 0);
    step(); smp();
    chk("t4_inc_id", bus.resp_id, 1); chk("t4_inc_data", bus.resp_data, 8'h11);

    // Set both flags so the reset clear is visible
    step(); drive1(1, OP_SUB, 8'h05, 8'h05, 1);
    step(); drive1(0, OP_ADD, 0, 0, 0);
    step(); smp(); chk("t5_flags", {bus.flags_c, bus.flags_z}, 2'b11);

    // Reset during EXEC drops the operation
    step(); drive0(1, OP_INC, 8'hFF, 8'h00, 1);
    smp(); chk("t6_req0_ready", bus.req0_ready, 1);
    step(); drive0(0, OP_ADD, 0, 0, 0);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("t6_rst_valid", bus.resp_valid, 0);
    chk("t6_rst_flags", {bus.flags_c, bus.flags_z}, 2'b00);
    chk("t6_rst_alu_a", bus.alu_a, 8'h00);
    @(posedge clk); #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); smp(); chk("t6_no_resp", bus.resp_valid, 0);
    end
    chk("t6_flags_after", {bus.flags_c, bus.flags_z}, 2'b00);

    // First tie after reset goes to port 0, then port 1
    step(); drive0(1, OP_ADD, 8'h03, 8'h04, 0); drive1(1, OP_ADD, 8'h07, 8'h08, 0);
    smp(); chk("t7_req0_ready", bus.req0_ready, 1); chk("t7_req1_ready", bus.req1_ready, 0);
    step(); drive0(0, OP_ADD, 0, 0, 0);
    smp(); chk("t7_exec_req1", bus.req1_ready, 0);
    step(); smp(); chk("t7_resp_data", bus.resp_data, 8'h07);
    step(); smp(); chk("t7_req1_turn", bus.req1_ready, 1);
    step(); drive1(0, OP_ADD, 0, 0, 0);
    repeat (3) step();
    smp(); chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
